cpu_hazard: RTL

- Pipeline sequencer for the 5-stage fritz CPU. Sits beside IF/ID/EX/MEM/WB.
- Detects load-use hazards in ID and inserts a bubble into ID/EX.
- Freezes the whole pipeline while the data memory is not ready, and gates branch/jump redirects.
- Traps a memory-wait timeout into a sticky error state.

---
 rtl/cpu_hazard.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/cpu_hazard.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cpu_hazard
//  Description : Pipeline sequencer for the 5-stage fritz CPU. Detects
//                load-use hazards in ID and inserts a bubble into ID/EX,
//                freezes the whole pipeline while data memory is not ready,
//                gates branch/jump redirects and traps a memory-wait timeout
//                into a sticky error state that only err_clr leaves.
//
//  Ports       : clk, rst (async, active high)
//                id_inst            - instruction held in IF/ID
//                ex_c_rfw, ex_c_wbsource, ex_rf_waddr - ID/EX load info
//                id_c_b, id_c_j     - branch taken / jump from decode
//                mem_req, mem_ready - MEM stage access handshake
//                err_clr            - leaves the error state
//                stall_if, stall_id, bubble_ex, freeze, take_redirect
//                mem_err            - sticky timeout flag
//                state              - FSM state (RUN/MEM_WAIT/ERR)
//
//  Options     : define CPU_HAZARD_PERF_EN to add the perf_cycles,
//                perf_lu_stalls and perf_mem_stalls counters (CNT_W wide).
//
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_hazard #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       id_inst,
    input  logic              ex_c_rfw,
    input  logic [1:0]        ex_c_wbsource,
    input  logic [4:0]        ex_rf_waddr,
    input  logic              id_c_b,
    input  logic              id_c_j,
    input  logic              mem_req,
    input  logic              mem_ready,
    input  logic              err_clr,
    output logic              stall_if,
    output logic              stall_id,
    output logic              bubble_ex,
    output logic              freeze,
    output logic              take_redirect,
    output logic              mem_err,
    output logic [1:0]        state
`ifdef CPU_HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0]  perf_cycles,
    output logic [CNT_W-1:0]  perf_lu_stalls,
    output logic [CNT_W-1:0]  perf_mem_stalls
`endif
);

    localparam logic [1:0] c_ST_RUN      = 2'd0;
    localparam logic [1:0] c_ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] c_ST_ERR      = 2'd2;

    localparam int unsigned         c_TO_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_TO_W-1:0]   c_TIMEOUT = c_TO_W'(MEM_TIMEOUT);
    localparam logic [c_TO_W-1:0]   c_TO_ONE  = c_TO_W'(1);

    logic [1:0]        r_state;
    logic [c_TO_W-1:0] r_cnt;
    logic              r_mem_err;

    logic [5:0] w_opcode;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic       w_uses_rt;
    logic       w_lu_haz;
    logic       w_mem_stall;
    logic       w_freeze;
    logic       w_stall;
    logic       w_bubble;
    logic       w_redirect;

    // Immediate/funct bits play no part in hazard detection.
    logic w_unused_inst;
    assign w_unused_inst = &{1'b0, id_inst[15:0]};

    // ------------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------------
    assign w_opcode = id_inst[31:26];
    assign w_rs     = id_inst[25:21];
    assign w_rt     = id_inst[20:16];

    // R-type, beq, bne and sw read rt; everything else uses rt as a target
    // or not at all, so a match there is not a real dependency.
    assign w_uses_rt = (w_opcode == 6'h00) || (w_opcode == 6'h04) ||
                       (w_opcode == 6'h05) || (w_opcode == 6'h2b);

    assign w_lu_haz = ex_c_rfw && (ex_c_wbsource == 2'h1) && (ex_rf_waddr != 5'd0) &&
                      ((ex_rf_waddr == w_rs) || (w_uses_rt && (ex_rf_waddr == w_rt)));

    // A ready in the same cycle as the request is a zero-wait access.
    assign w_mem_stall = mem_req && !mem_ready;

    // Combinational so the first stalled cycle is already frozen.
    assign w_freeze = (r_state == c_ST_ERR) ||
                      (((r_state == c_ST_RUN) || (r_state == c_ST_MEM_WAIT)) && w_mem_stall);

    // Priority: freeze (ERR or memory) > load-use bubble > redirect.
    // During freeze ID/EX holds its contents rather than being bubbled.
    always_comb begin
        w_stall    = 1'b0;
        w_bubble   = 1'b0;
        w_redirect = 1'b0;
        if (w_freeze) begin
            w_stall = 1'b1;
        end else if (w_lu_haz) begin
            w_stall  = 1'b1;
            w_bubble = 1'b1;
        end else begin
            w_redirect = id_c_b || id_c_j;
        end
    end

    assign stall_if      = w_stall;
    assign stall_id      = w_stall;
    assign bubble_ex     = w_bubble;
    assign freeze        = w_freeze;
    assign take_redirect = w_redirect;
    assign mem_err       = r_mem_err;
    assign state         = r_state;

    // ------------------------------------------------------------------------
    // Memory-wait FSM with timeout counter. r_cnt counts consecutive stalled
    // cycles; it is left at MEM_TIMEOUT on entry to ERR and never wraps.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_ST_RUN;
            r_cnt     <= '0;
            r_mem_err <= 1'b0;
        end else begin
            case (r_state)
                c_ST_RUN: begin
                    if (w_mem_stall) begin
                        r_state <= c_ST_MEM_WAIT;
                        r_cnt   <= c_TO_ONE;
                    end
                end
                c_ST_MEM_WAIT: begin
                    if (w_mem_stall) begin
                        if (r_cnt == c_TIMEOUT) begin
                            r_state   <= c_ST_ERR;
                            r_mem_err <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + c_TO_ONE;
                        end
                    end else begin
                        // Either the access completed or it was aborted.
                        r_state <= c_ST_RUN;
                        r_cnt   <= '0;
                    end
                end
                c_ST_ERR: begin
                    if (err_clr) begin
                        r_state   <= c_ST_RUN;
                        r_cnt     <= '0;
                        r_mem_err <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_ST_RUN;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

`ifdef CPU_HAZARD_PERF_EN
    // ------------------------------------------------------------------------
    // Performance counters, free-running modulo 2^CNT_W.
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] r_perf_cycles;
    logic [CNT_W-1:0] r_perf_lu_stalls;
    logic [CNT_W-1:0] r_perf_mem_stalls;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_cycles     <= '0;
            r_perf_lu_stalls  <= '0;
            r_perf_mem_stalls <= '0;
        end else begin
            r_perf_cycles     <= r_perf_cycles + CNT_W'(1);
            r_perf_lu_stalls  <= r_perf_lu_stalls + CNT_W'(w_bubble);
            r_perf_mem_stalls <= r_perf_mem_stalls + CNT_W'(w_freeze);
        end
    end

    assign perf_cycles     = r_perf_cycles;
    assign perf_lu_stalls  = r_perf_lu_stalls;
    assign perf_mem_stalls = r_perf_mem_stalls;
`else
    localparam int unsigned c_unused_cnt_w = CNT_W;
`endif

endmodule
`default_nettype wire
